// File: rtl/sm_seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: frame-synchronous buffered updates,
// per-slot dead time, brightness PWM and optional leading-zero blanking.
module sm_seven_seg_scan_ctrl #(
  parameter int DIGITS     = 3,
  parameter int PRESCALE   = 1024,
  parameter int SLOT_TICKS = 16,
  parameter int DEAD_TICKS = 1
) (
  input  logic                  clkIn,
  input  logic                  rst,
  input  logic                  load,
  output logic                  ready,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  blank_lz,
  input  logic [3:0]            bright,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     dig_en,
  output logic                  frame_done
);

  // state    | meaning
  // ST_DEAD  | blank guard ticks at the start of every slot
  // ST_ON    | current digit driven (unless blanked)
  // ST_OFF   | remainder of the slot dark (brightness PWM)
  typedef enum logic [1:0] {ST_DEAD, ST_ON, ST_OFF} state_e;

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [3:0]    T_LAST   = 4'(SLOT_TICKS - 1);
  localparam logic [DW-1:0] D_LAST   = DW'(DIGITS - 1);
  localparam logic [4:0]    DEAD_T   = 5'(DEAD_TICKS);
  localparam logic [4:0]    ON_MAX   = 5'(SLOT_TICKS - DEAD_TICKS);

  logic [PW-1:0]       pre_q, pre_d;
  logic [3:0]          t_q, t_d;
  logic [DW-1:0]       d_q, d_d;
  state_e              st_q, st_d;

  logic                pend_full_q, pend_full_d;
  logic [4*DIGITS-1:0] pend_val_q, pend_val_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                pend_blz_q, pend_blz_d;
  logic [3:0]          pend_br_q, pend_br_d;

  logic [4*DIGITS-1:0] act_val_q, act_val_d;
  logic [DIGITS-1:0]   act_dp_q, act_dp_d;
  logic                act_blz_q, act_blz_d;
  logic [3:0]          act_br_q, act_br_d;

  logic [DIGITS-1:0]   dig_en_q, dig_en_d;
  logic [6:0]          seg_q, seg_d;
  logic                seg_dp_q, seg_dp_d;
  logic                frame_done_q, frame_done_d;

  logic                tick, boundary, accept, apply;
  logic [4:0]          lit_len;
  logic [DIGITS-1:0]   blank_vec;
  logic                zero_above;
  logic [3:0]          nib;
  logic                dp_sel, blank_sel;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Scan timebase
  always_comb begin
    tick     = (pre_q == PRE_LAST);
    boundary = tick && (t_q == T_LAST) && (d_q == D_LAST);
    pre_d    = tick ? '0 : pre_q + 1'b1;
    t_d      = t_q;
    d_d      = d_q;
    if (tick) begin
      if (t_q == T_LAST) begin
        t_d = '0;
        d_d = (d_q == D_LAST) ? '0 : d_q + 1'b1;
      end else begin
        t_d = t_q + 1'b1;
      end
    end
  end

  // Pending/active buffers; a boundary with a full buffer applies and never accepts
  always_comb begin
    accept      = load && !pend_full_q;
    apply       = boundary && pend_full_q;
    pend_full_d = pend_full_q;
    pend_val_d  = pend_val_q;
    pend_dp_d   = pend_dp_q;
    pend_blz_d  = pend_blz_q;
    pend_br_d   = pend_br_q;
    act_val_d   = act_val_q;
    act_dp_d    = act_dp_q;
    act_blz_d   = act_blz_q;
    act_br_d    = act_br_q;
    if (apply) begin
      pend_full_d = 1'b0;
      act_val_d   = pend_val_q;
      act_dp_d    = pend_dp_q;
      act_blz_d   = pend_blz_q;
      act_br_d    = pend_br_q;
    end else if (accept) begin
      pend_full_d = 1'b1;
      pend_val_d  = value;
      pend_dp_d   = dp;
      pend_blz_d  = blank_lz;
      pend_br_d   = bright;
    end
  end

  // Slot FSM; state only moves on a tick, evaluated against the upcoming t
  always_comb begin
    lit_len = ({1'b0, act_br_d} < ON_MAX) ? {1'b0, act_br_d} : ON_MAX;
    st_d    = st_q;
    if (tick) begin
      if ({1'b0, t_d} < DEAD_T)                st_d = ST_DEAD;
      else if ({1'b0, t_d} < DEAD_T + lit_len) st_d = ST_ON;
      else                                     st_d = ST_OFF;
    end
  end

  // Output decode uses next-state values so registered outputs track the scan
  always_comb begin
    blank_vec  = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above   = zero_above && (act_val_d[4*i +: 4] == 4'h0);
      blank_vec[i] = act_blz_d && (i != 0) && zero_above;
    end
    nib       = 4'h0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (DW'(i) == d_d) begin
        nib       = act_val_d[4*i +: 4];
        dp_sel    = act_dp_d[i];
        blank_sel = blank_vec[i];
      end
    end
    dig_en_d     = '0;
    seg_d        = '0;
    seg_dp_d     = 1'b0;
    frame_done_d = boundary;
    if (st_d == ST_ON && !blank_sel) begin
      for (int i = 0; i < DIGITS; i++) dig_en_d[i] = (DW'(i) == d_d);
      seg_d    = hex7(nib);
      seg_dp_d = dp_sel;
    end
  end

  always_ff @(posedge clkIn) begin
    if (rst) begin
      pre_q        <= '0;
      t_q          <= '0;
      d_q          <= '0;
      st_q         <= ST_DEAD;
      pend_full_q  <= 1'b0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_blz_q   <= 1'b0;
      pend_br_q    <= '0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      act_blz_q    <= 1'b0;
      act_br_q     <= 4'hF;
      dig_en_q     <= '0;
      seg_q        <= '0;
      seg_dp_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      t_q          <= t_d;
      d_q          <= d_d;
      st_q         <= st_d;
      pend_full_q  <= pend_full_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_blz_q   <= pend_blz_d;
      pend_br_q    <= pend_br_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      act_blz_q    <= act_blz_d;
      act_br_q     <= act_br_d;
      dig_en_q     <= dig_en_d;
      seg_q        <= seg_d;
      seg_dp_q     <= seg_dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ready      = !pend_full_q;
  assign dig_en     = dig_en_q;
  assign seg        = seg_q;
  assign seg_dp     = seg_dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sm_seven_seg_scan_ctrl.sv
// Scoreboard bench: expected per-frame display pushed when stimulus is driven,
// compared against the frame observed between consecutive frame_done pulses.
module tb_sm_seven_seg_scan_ctrl;
  localparam int DIGITS = 3, PRESCALE = 2, SLOT_TICKS = 4, DEAD_TICKS = 1;
  localparam int FRAME = DIGITS * SLOT_TICKS * PRESCALE;

  logic        clk = 1'b0, rst = 1'b1, load = 1'b0;
  logic [11:0] value = '0;
  logic [2:0]  dp = '0;
  logic        blank_lz = 1'b0;
  logic [3:0]  bright = '0;
  logic        ready, seg_dp, frame_done;
  logic [6:0]  seg;
  logic [2:0]  dig_en;

  sm_seven_seg_scan_ctrl #(
    .DIGITS(DIGITS), .PRESCALE(PRESCALE), .SLOT_TICKS(SLOT_TICKS), .DEAD_TICKS(DEAD_TICKS)
  ) dut (
    .clkIn(clk), .rst(rst), .load(load), .ready(ready), .value(value), .dp(dp),
    .blank_lz(blank_lz), .bright(bright), .seg(seg), .seg_dp(seg_dp),
    .dig_en(dig_en), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0][7:0] lit;
    logic [2:0][6:0] seg;
    logic [2:0]      dpv;
    logic [2:0][7:0] first;
  } frame_t;

  frame_t      sb_q[$];
  int          n_chk = 0, n_fail = 0;
  logic [11:0] cur_v;
  logic [2:0]  cur_p;
  logic        cur_bz;
  logic [3:0]  cur_b;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Expected appearance of one whole frame for a given active content
  function automatic frame_t model(input logic [11:0] v, input logic [2:0] p,
                                   input logic bz, input logic [3:0] b);
    frame_t f;
    int     on;
    logic   blank;
    f  = '0;
    on = (b > 4'd3) ? 3 : int'(b);
    for (int d = 0; d < 3; d++) begin
      blank = bz && (d > 0) && ((v >> (4 * d)) == 12'h0);
      if (blank || on == 0) begin
        f.first[d] = 8'hFF;
      end else begin
        f.lit[d]   = 8'(on * PRESCALE);
        f.seg[d]   = hex7(v[4*d +: 4]);
        f.dpv[d]   = p[d];
        f.first[d] = 8'(d * SLOT_TICKS * PRESCALE + DEAD_TICKS * PRESCALE);
      end
    end
    return f;
  endfunction

  // Monitor: one observed frame per frame_done-to-frame_done window
  initial begin : mon
    frame_t obs, e;
    bit     coll;
    int     cyc, bad;
    coll = 0; cyc = 0; bad = 0; obs = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        coll = 0;
      end else begin
        if (frame_done) begin
          if (coll) begin
            chk("frame_len", cyc, FRAME);
            chk("frame_glitch", bad, 0);
            if (sb_q.size() == 0) chk("sb_underflow", 0, 1);
            else begin
              e = sb_q.pop_front();
              for (int d = 0; d < 3; d++) begin
                chk($sformatf("lit_d%0d", d), obs.lit[d], e.lit[d]);
                chk($sformatf("seg_d%0d", d), obs.seg[d], e.seg[d]);
                chk($sformatf("dp_d%0d", d), obs.dpv[d], e.dpv[d]);
                chk($sformatf("first_d%0d", d), obs.first[d], e.first[d]);
              end
            end
          end
          coll = 1; cyc = 0; bad = 0;
          obs = '0;
          obs.first = {3{8'hFF}};
        end
        if (coll) begin
          if (dig_en == 3'b000) begin
            if (seg != 7'h0 || seg_dp != 1'b0) bad++;
          end else if ($countones(dig_en) != 1) begin
            bad++;
          end else begin
            for (int d = 0; d < 3; d++) begin
              if (dig_en[d]) begin
                if (obs.lit[d] == 8'd0) begin
                  obs.first[d] = 8'(cyc);
                  obs.seg[d]   = seg;
                  obs.dpv[d]   = seg_dp;
                end else if (seg != obs.seg[d] || seg_dp != obs.dpv[d]) begin
                  bad++;
                end
                obs.lit[d] = obs.lit[d] + 8'd1;
              end
            end
          end
          cyc++;
        end
      end
    end
  end

  task automatic wait_fd();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 100);
    if (!frame_done) chk("fd_timeout", 0, 1);
  endtask

  task automatic do_load(input logic [11:0] v, input logic [2:0] p,
                         input logic bz, input logic [3:0] b);
    chk("ready_before_load", ready, 1);
    value = v; dp = p; blank_lz = bz; bright = b; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("ready_after_load", ready, 0);
  endtask

  // Push the frame for the window now starting, optionally load the next content
  task automatic step(input bit ld, input logic [11:0] v, input logic [2:0] p,
                      input logic bz, input logic [3:0] b);
    sb_q.push_back(model(cur_v, cur_p, cur_bz, cur_b));
    if (ld) begin
      repeat (3) @(negedge clk);
      do_load(v, p, bz, b);
    end
    wait_fd();
    chk("ready_at_fd", ready, 1);
    if (ld) begin
      cur_v = v; cur_p = p; cur_bz = bz; cur_b = b;
    end
  endtask

  // Called at the negedge where rst was just released (scan cycle 0)
  task automatic restart_check();
    int k, first;
    k = 0; first = -1;
    while (k < 60) begin
      @(negedge clk);
      k++;
      if (dig_en != 3'b000 && first < 0) begin
        first = k;
        chk("restart_dig", dig_en, 3'b001);
        chk("restart_seg", seg, 7'h3F);
      end
      if (frame_done) break;
    end
    chk("restart_first_lit", first, DEAD_TICKS * PRESCALE);
    chk("restart_fd", k, FRAME);
  endtask

  initial begin : drv
    int n, hi;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_dig_en", dig_en, 0);
    chk("rst_seg", seg, 0);
    chk("rst_seg_dp", seg_dp, 0);
    chk("rst_fd", frame_done, 0);
    cur_v = 12'h000; cur_p = 3'b000; cur_bz = 1'b0; cur_b = 4'd15;
    rst = 1'b0;
    restart_check();

    step(1, 12'h1A7, 3'b010, 1'b0, 4'd15);
    step(1, 12'h1A7, 3'b010, 1'b0, 4'd0);
    step(1, 12'h1A7, 3'b010, 1'b0, 4'd1);
    step(1, 12'h1A7, 3'b010, 1'b0, 4'd9);
    step(1, 12'h005, 3'b000, 1'b1, 4'd15);
    step(1, 12'h000, 3'b000, 1'b1, 4'd15);
    step(1, 12'h105, 3'b000, 1'b1, 4'd15);

    // Back-to-back loads: second one must be dropped
    sb_q.push_back(model(cur_v, cur_p, cur_bz, cur_b));
    repeat (3) @(negedge clk);
    chk("hs_ready0", ready, 1);
    value = 12'h123; dp = 3'b000; blank_lz = 1'b0; bright = 4'd15; load = 1'b1;
    @(negedge clk);
    chk("hs_ready1", ready, 0);
    value = 12'h456;
    @(negedge clk);
    load = 1'b0;
    hi = 0; n = 0;
    while (!frame_done && n < 100) begin
      if (ready) hi++;
      @(negedge clk);
      n++;
    end
    if (!frame_done) chk("hs_fd_timeout", 0, 1);
    chk("hs_ready_held_low", hi, 0);
    chk("hs_ready_fd", ready, 1);
    cur_v = 12'h123; cur_p = 3'b000; cur_bz = 1'b0; cur_b = 4'd15;

    // Load landing exactly on the frame-boundary cycle
    sb_q.push_back(model(cur_v, cur_p, cur_bz, cur_b));
    repeat (FRAME - 1) @(negedge clk);
    chk("bl_pre_fd", frame_done, 0);
    chk("bl_ready", ready, 1);
    value = 12'h789; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("bl_fd", frame_done, 1);
    chk("bl_ready_after", ready, 0);
    sb_q.push_back(model(cur_v, cur_p, cur_bz, cur_b));
    wait_fd();
    chk("bl_ready_applied", ready, 1);
    cur_v = 12'h789;
    sb_q.push_back(model(cur_v, cur_p, cur_bz, cur_b));
    wait_fd();

    // Reset while digit1 is lit, with a pending value that must be discarded
    @(negedge clk);
    value = 12'hABC; dp = 3'b111; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("rst_pend_ready", ready, 0);
    n = 0;
    while (dig_en != 3'b010 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("rst_wait_d1", dig_en, 3'b010);
    rst = 1'b1;
    @(negedge clk);
    sb_q.delete();
    chk("midrst_dig_en", dig_en, 0);
    chk("midrst_seg", seg, 0);
    chk("midrst_seg_dp", seg_dp, 0);
    chk("midrst_fd", frame_done, 0);
    chk("midrst_ready", ready, 1);
    @(negedge clk);
    rst = 1'b0;
    cur_v = 12'h000; cur_p = 3'b000; cur_bz = 1'b0; cur_b = 4'd15;
    restart_check();
    sb_q.push_back(model(cur_v, cur_p, cur_bz, cur_b));
    wait_fd();
    repeat (2) @(negedge clk);
    chk("sb_drain", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sm_seven_seg_scan_ctrl.md
# sm_seven_seg_scan_ctrl

Scan controller for a multiplexed seven-segment display whose digits share one segment bus. It accepts a hex value and decimal points from the core side through a one-deep pending buffer and applies the update only at a frame boundary, so a digit never shows a mix of old and new data. It time-slices the shared segment lines across `DIGITS` digit enables, inserts dead time between digits to prevent ghosting, and applies per-frame brightness PWM and optional leading-zero blanking. It sits between the register tap of `sm_top` and the board GPIO segment and digit pins.

## Interface
- `DIGITS`, 3, number of digits scanned (1..8).
- `PRESCALE`, 1024, clock cycles per scan tick (>=1).
- `SLOT_TICKS`, 16, ticks per digit slot (2..16).
- `DEAD_TICKS`, 1, blank ticks at the start of every slot (1..SLOT_TICKS-1).
- `clkIn`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `load`  in  1  request to capture `value`, `dp`, `blank_lz`, `bright`.
- `ready`  out  1  pending buffer empty; `load` is accepted only when `ready`=1.
- `value`  in  4*DIGITS  hex nibbles; nibble 0 is the rightmost digit.
- `dp`  in  DIGITS  decimal point per digit.
- `blank_lz`  in  1  enable leading-zero blanking.
- `bright`  in  4  lit ticks per slot, 0 = dark.
- `seg`  out  7  segments, active-high, bit0=a … bit6=g.
- `seg_dp`  out  1  decimal point, active-high.
- `dig_en`  out  DIGITS  digit enables, one-hot or zero, active-high.
- `frame_done`  out  1  one-cycle pulse at the end of the last digit's slot.

## Operation
- **Prescaler.** Counts 0..PRESCALE-1. `tick`=1 when count = PRESCALE-1.
- **Slot tick counter.** `t` runs 0..SLOT_TICKS-1 and advances on `tick`. When it wraps, the digit index `d` advances 0..DIGITS-1 and wraps to 0.
- **Frame boundary.** The cycle in which `tick`=1, `t`=SLOT_TICKS-1 and `d`=DIGITS-1.
- **Per-slot FSM.**
  - DEAD while `t` < DEAD_TICKS.
  - ON while DEAD_TICKS <= `t` < DEAD_TICKS+min(`bright_act`, SLOT_TICKS-DEAD_TICKS).
  - OFF otherwise.
  - Each slot starts in DEAD.
- **Outputs by state.**
  - In ON with digit `d` not blanked: `dig_en`=1<<`d`, `seg`=decode(nibble `d`), `seg_dp`=`dp_act`[d].
  - In all other cases: `dig_en`, `seg` and `seg_dp` are all 0.
- **Decode table** (hex, bit order g..a):
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
- **Leading-zero blanking.** When the active `blank_lz`=1, digit `d` > 0 is blanked if nibbles `d`..DIGITS-1 are all 0. Digit 0 is never blanked. A blanked digit is dark, including its DP.
- **Load handshake.**
  - `load`=1 with `ready`=1 captures the inputs into the pending buffer; `ready` goes to 0 the next cycle.
  - `load` while `ready`=0 is ignored and has no effect.
- **Apply.** At a frame boundary, if the pending buffer is full, its contents are copied to the active buffer (`value_act`, `dp_act`, `blank_lz_act`, `bright_act`). The pending buffer is then empty and `ready`=1 the next cycle.
- **Load on a boundary cycle.** A `load` accepted in the frame-boundary cycle while the pending buffer is empty goes into the pending buffer only. It is applied at the following frame boundary.
- **Brightness changes.** `bright_act` changes only at frame boundaries, so there is no mid-frame brightness change.
- **Reset values.**
  - Active buffer: value 0, dp 0, blank_lz 0, bright 15.
  - Pending buffer empty, `ready`=1.
  - `d`=0, `t`=0, prescaler 0.
  - `dig_en`, `seg`, `seg_dp`, `frame_done` all 0.

## Timing
- All outputs are registered. Outputs reflect state changes caused by a `tick` one cycle after that tick cycle.
- Slot length = SLOT_TICKS*PRESCALE cycles. Frame length = DIGITS*SLOT_TICKS*PRESCALE cycles.
- Dead time is at least DEAD_TICKS*PRESCALE cycles between any two digit enables, including the wrap from the last digit back to digit 0.
- `frame_done` is high for exactly the cycle after the frame-boundary cycle; the new active data is visible from that same cycle.
- If `rst` is asserted mid-slot, all outputs are 0 the next cycle. The pending buffer is discarded, and scanning restarts at `d`=0 in DEAD.
- Latency from an accepted `load` to display is at most one full frame plus one cycle.

## Test plan
Bench parameters: DIGITS=3, PRESCALE=2, SLOT_TICKS=4, DEAD_TICKS=1. This gives an 8-cycle slot and a 24-cycle frame.

- **Reset and idle scan.** Release reset with no `load`.
  - `ready`=1.
  - Each 8-cycle slot shows 2 dark cycles, then `dig_en`=001, 010, 100 in turn for 6 cycles each with `seg`=3F.
  - `frame_done` pulses every 24 cycles.
- **Basic load.** Load `value`=0x1A7, `dp`=010, `bright`=15, `blank_lz`=0.
  - The current frame is unchanged.
  - After `frame_done`: digit0 `seg`=07, digit1 `seg`=77 with `seg_dp`=1, digit2 `seg`=06.
- **Brightness.**
  - `bright`=0: `dig_en` stays 000 for a whole frame.
  - `bright`=1: each digit is lit exactly 2 cycles per slot.
  - `bright`=9: each digit is lit 6 cycles per slot (clamped to 3 ticks).
- **Leading-zero blanking.**
  - `value`=0x005, `blank_lz`=1: digits 2 and 1 stay dark; digit0 `seg`=6D.
  - `value`=0x000: only digit0 is lit, `seg`=3F.
  - `value`=0x105: all three digits are lit.
- **Handshake.**
  - Two loads on consecutive cycles (0x123 then 0x456): only 0x123 is shown; `ready` stays low until the cycle after the boundary.
  - A load of 0x789 in the boundary cycle with an empty pending buffer appears only after the next `frame_done`.
- **Reset during ON.** Assert `rst` while digit1 is lit.
  - All outputs are 0 the next cycle.
  - After release, the scan restarts at digit0 showing `seg`=3F.
  - A pending value loaded before the reset is never displayed.
